// File: rtl/audio_dac_serializer_if.sv
// User-side sample port of the audio DAC serializer: stereo pair, write strobe, flush, allowed.
// No latency of its own; audio_out_allowed reflects the serializer FIFO occupancy directly.
// The master must only count a pair as accepted when write_audio_out and audio_out_allowed are both high.
interface audio_dac_serializer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] left_channel_audio_out;
  logic [DATA_WIDTH-1:0] right_channel_audio_out;
  logic                  write_audio_out;
  logic                  clear_audio_out_memory;
  logic                  audio_out_allowed;

  modport master (
    output left_channel_audio_out,
    output right_channel_audio_out,
    output write_audio_out,
    output clear_audio_out_memory,
    input  audio_out_allowed
  );

  modport slave (
    input  left_channel_audio_out,
    input  right_channel_audio_out,
    input  write_audio_out,
    input  clear_audio_out_memory,
    output audio_out_allowed
  );
endinterface

// File: rtl/audio_dac_serializer.sv
// Buffers stereo pairs in a small FIFO and shifts them MSB-first, left-justified, onto AUD_DACDAT.
// Codec pin edges act 3 CLOCK_50 cycles after they occur; AUD_DACDAT follows one cycle after each load/shift.
// audio_out_allowed drops while the FIFO is full; writes then are dropped. Option: AUDIO_DAC_UNDERFLOW_REPEAT_EN.
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  audio_dac_serializer_if.slave aud_if,
  input  logic               AUD_BCLK,
  input  logic               AUD_DACLRCK,
  output logic               AUD_DACDAT,
  output logic [PTR_W:0]     fifo_level,
  output logic               underflow
);

  typedef enum logic [1:0] {ST_IDLE, ST_LEFT, ST_RIGHT} state_t;
  localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] LEVEL_ONE  = (PTR_W+1)'(1);

  state_t                  state_q, state_d;
  logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [2*DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]          level_q, level_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d, hold_q, hold_d;
  logic                    dacdat_q, dacdat_d, underflow_q, underflow_d;
  logic                    bclk_s1_q, bclk_s2_q, bclk_prev_q;
  logic                    lrck_s1_q, lrck_s2_q, lrck_prev_q;
  // Masks the bogus edge seen while the synchronizers fill after reset.
  logic [1:0]              warm_q, warm_d;
`ifdef AUDIO_DAC_UNDERFLOW_REPEAT_EN
  logic [2*DATA_WIDTH-1:0] last_q, last_d;
`endif

  logic                    sync_ok, bclk_fall, lrck_rise, lrck_fall;
  logic                    do_write, fifo_avail, do_pop;
  logic [2*DATA_WIDTH-1:0] head, fill;

  assign aud_if.audio_out_allowed = (level_q != LEVEL_FULL);
  assign fifo_level = level_q;
  assign underflow  = underflow_q;
  assign AUD_DACDAT = dacdat_q;

  // Edge detection, FIFO bookkeeping, frame state machine and shifter next-state.
  always_comb begin
    warm_d      = (warm_q == 2'd3) ? 2'd3 : warm_q + 2'd1;
    sync_ok     = (warm_q == 2'd3);
    bclk_fall   = sync_ok & bclk_prev_q & ~bclk_s2_q;
    lrck_rise   = sync_ok & lrck_s2_q & ~lrck_prev_q;
    lrck_fall   = sync_ok & ~lrck_s2_q & lrck_prev_q;

    head        = mem_q[rd_ptr_q];
    do_write    = aud_if.write_audio_out & aud_if.audio_out_allowed;
    // A flush in the same cycle as a frame start leaves nothing to pop.
    fifo_avail  = (level_q != '0) & ~aud_if.clear_audio_out_memory;
    do_pop      = lrck_rise & fifo_avail;
    underflow_d = lrck_rise & ~fifo_avail;
`ifdef AUDIO_DAC_UNDERFLOW_REPEAT_EN
    fill        = last_q;
    last_d      = do_pop ? head : last_q;
`else
    fill        = '0;
`endif

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (aud_if.clear_audio_out_memory) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_write) begin
        mem_d[wr_ptr_q] = {aud_if.left_channel_audio_out, aud_if.right_channel_audio_out};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_write, do_pop})
        2'b10:   level_d = level_q + LEVEL_ONE;
        2'b01:   level_d = level_q - LEVEL_ONE;
        default: level_d = level_q;
      endcase
    end

    // A new frame edge always wins over a bit-clock shift in the same cycle.
    state_d = state_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    if (lrck_rise) begin
      shift_d = do_pop ? head[2*DATA_WIDTH-1:DATA_WIDTH] : fill[2*DATA_WIDTH-1:DATA_WIDTH];
      hold_d  = do_pop ? head[DATA_WIDTH-1:0] : fill[DATA_WIDTH-1:0];
      state_d = ST_LEFT;
    end else if (lrck_fall && state_q == ST_LEFT) begin
      shift_d = hold_q;
      state_d = ST_RIGHT;
    end else if (bclk_fall) begin
      shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
    end

    dacdat_d = (state_q == ST_IDLE) ? 1'b0 : shift_q[DATA_WIDTH-1];
  end

  // All state registers; codec pins are resynchronized here too.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      dacdat_q    <= 1'b0;
      underflow_q <= 1'b0;
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_prev_q <= 1'b0;
      lrck_s1_q   <= 1'b0;
      lrck_s2_q   <= 1'b0;
      lrck_prev_q <= 1'b0;
      warm_q      <= 2'd0;
`ifdef AUDIO_DAC_UNDERFLOW_REPEAT_EN
      last_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      dacdat_q    <= dacdat_d;
      underflow_q <= underflow_d;
      bclk_s1_q   <= AUD_BCLK;
      bclk_s2_q   <= bclk_s1_q;
      bclk_prev_q <= bclk_s2_q;
      lrck_s1_q   <= AUD_DACLRCK;
      lrck_s2_q   <= lrck_s1_q;
      lrck_prev_q <= lrck_s2_q;
      warm_q      <= warm_d;
`ifdef AUDIO_DAC_UNDERFLOW_REPEAT_EN
      last_q      <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer: drives codec clocks and sample writes, checks serial output.
// Codec pins and writes change on the CLOCK_50 falling edge; outputs are sampled on falling edges.
// Expected data comes from hand-computed constants and a one-register model of the last popped pair.
module tb_audio_dac_serializer;
  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       AUD_BCLK = 1'b1;
  logic       AUD_DACLRCK = 1'b0;
  logic       AUD_DACDAT;
  logic [2:0] fifo_level;
  logic       underflow;

  int err_cnt = 0;
  int chk_cnt = 0;
  int uf_cnt  = 0;

  audio_dac_serializer_if #(.DATA_WIDTH(32)) aud_if ();

  audio_dac_serializer #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .PTR_W(2)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .aud_if      (aud_if),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_DACDAT  (AUD_DACDAT),
    .fifo_level  (fifo_level),
    .underflow   (underflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Counts cycles with underflow high, sampled away from the active edge.
  always @(negedge CLOCK_50) if (underflow) uf_cnt <= uf_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic write_pair(input logic [31:0] l, input logic [31:0] r);
    aud_if.left_channel_audio_out  = l;
    aud_if.right_channel_audio_out = r;
    aud_if.write_audio_out = 1'b1;
    @(negedge CLOCK_50);
    aud_if.write_audio_out = 1'b0;
  endtask

  // One half-frame: LRCK moves with a BCLK fall, then nbits bits are sampled MSB-first.
  // A full half also samples one extra bit (must be 0) and ends with BCLK high.
  task automatic play_half(input logic lvl, input int nbits, output logic [31:0] got, output logic tail);
    got  = '0;
    tail = 1'b0;
    AUD_DACLRCK = lvl;
    AUD_BCLK    = 1'b0;
    wait_clk(6);
    got[31] = AUD_DACDAT;
    for (int i = 1; i < nbits; i++) begin
      AUD_BCLK = 1'b1; wait_clk(6);
      AUD_BCLK = 1'b0; wait_clk(6);
      got[5'(31 - i)] = AUD_DACDAT;
    end
    if (nbits == 32) begin
      AUD_BCLK = 1'b1; wait_clk(6);
      AUD_BCLK = 1'b0; wait_clk(6);
      tail = AUD_DACDAT;
      AUD_BCLK = 1'b1; wait_clk(6);
    end
  endtask

  task automatic play_frame(output logic [63:0] pair);
    logic [31:0] l, r;
    logic        t;
    play_half(1'b1, 32, l, t);
    play_half(1'b0, 32, r, t);
    pair = {l, r};
  endtask

  logic [63:0] last_pair = '0;

  function automatic logic [63:0] uf_exp();
`ifdef AUDIO_DAC_UNDERFLOW_REPEAT_EN
    return last_pair;
`else
    return 64'h0;
`endif
  endfunction

  initial begin
    logic [63:0] pairs [5];
    logic [63:0] fr;
    logic [31:0] h;
    logic        t;
    int          uf0;

    aud_if.left_channel_audio_out  = '0;
    aud_if.right_channel_audio_out = '0;
    aud_if.write_audio_out         = 1'b0;
    aud_if.clear_audio_out_memory  = 1'b0;
    pairs[0] = 64'h11111111_22222222;
    pairs[1] = 64'h33333333_44444444;
    pairs[2] = 64'h80000001_7FFFFFFE;
    pairs[3] = 64'hDEADBEEF_CAFEF00D;
    pairs[4] = 64'h55555555_AAAAAAAA;

    // Reset state.
    wait_clk(3);
    check("rst_dacdat", 64'(AUD_DACDAT), 64'd0);
    check("rst_allowed", 64'(aud_if.audio_out_allowed), 64'd1);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_underflow", 64'(underflow), 64'd0);
    reset_n = 1'b1;
    wait_clk(8);

    // Single pair, bit order and level change on the frame start.
    write_pair(32'hA5000001, 32'h5A000002);
    check("t1_level_before", 64'(fifo_level), 64'd1);
    play_half(1'b1, 32, h, t);
    check("t1_left_bits", 64'(h), 64'hA5000001);
    check("t1_left_tail", 64'(t), 64'd0);
    check("t1_level_after", 64'(fifo_level), 64'd0);
    play_half(1'b0, 32, h, t);
    check("t1_right_bits", 64'(h), 64'h5A000002);
    last_pair = 64'hA5000001_5A000002;

    // Fill past full, then drain in order.
    for (int i = 0; i < 4; i++) write_pair(pairs[i][63:32], pairs[i][31:0]);
    check("t2_allowed_full", 64'(aud_if.audio_out_allowed), 64'd0);
    write_pair(pairs[4][63:32], pairs[4][31:0]);
    check("t2_level_full", 64'(fifo_level), 64'd4);
    for (int i = 0; i < 4; i++) begin
      play_frame(fr);
      check($sformatf("t2_frame%0d", i), fr, pairs[i]);
    end
    last_pair = pairs[3];
    check("t2_allowed_empty", 64'(aud_if.audio_out_allowed), 64'd1);

    // Underflow: one pulse, zeros (or the repeated pair).
    uf0 = uf_cnt;
    play_frame(fr);
    check("t3_uf_data", fr, uf_exp());
    check("t3_uf_pulse", 64'(uf_cnt - uf0), 64'd1);
    check("t3_level", 64'(fifo_level), 64'd0);

    // Flush while full, with a coincident write; the frame in flight finishes.
    write_pair(32'h0F0F0F0F, 32'hC3C3C3C3);
    play_half(1'b1, 32, h, t);
    check("t5_left_bits", 64'(h), 64'h0F0F0F0F);
    last_pair = 64'h0F0F0F0F_C3C3C3C3;
    for (int i = 0; i < 4; i++) write_pair(pairs[4][63:32], pairs[4][31:0]);
    check("t5_allowed_full", 64'(aud_if.audio_out_allowed), 64'd0);
    aud_if.clear_audio_out_memory  = 1'b1;
    aud_if.write_audio_out         = 1'b1;
    aud_if.left_channel_audio_out  = 32'h12345678;
    aud_if.right_channel_audio_out = 32'h9ABCDEF0;
    @(negedge CLOCK_50);
    aud_if.clear_audio_out_memory = 1'b0;
    aud_if.write_audio_out        = 1'b0;
    check("t5_level_cleared", 64'(fifo_level), 64'd0);
    play_half(1'b0, 32, h, t);
    check("t5_right_bits", 64'(h), 64'hC3C3C3C3);
    uf0 = uf_cnt;
    play_frame(fr);
    check("t5_after_clear", fr, uf_exp());
    check("t5_uf_pulse", 64'(uf_cnt - uf0), 64'd1);

    // Reset at bit 10 of the left half, released with LRCK high.
    write_pair(32'hFFC00000, 32'h00000000);
    write_pair(32'h77777777, 32'h88888888);
    play_half(1'b1, 10, h, t);
    check("t6_partial_bits", 64'(h[31:22]), 64'h3FF);
    reset_n = 1'b0;
    #1;
    check("t6_rst_dacdat", 64'(AUD_DACDAT), 64'd0);
    check("t6_rst_level", 64'(fifo_level), 64'd0);
    wait_clk(3);
    reset_n = 1'b1;
    last_pair = '0;
    wait_clk(8);
    write_pair(32'h600DCAFE, 32'hBADC0FFE);
    uf0 = uf_cnt;
    play_half(1'b0, 32, h, t);
    check("t6_idle_right_zero", 64'(h), 64'd0);
    check("t6_no_pop", 64'(fifo_level), 64'd1);
    check("t6_no_spurious_uf", 64'(uf_cnt - uf0), 64'd0);
    play_frame(fr);
    check("t6_restart_frame", fr, 64'h600DCAFE_BADC0FFE);
    check("t6_level_after", 64'(fifo_level), 64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
